// File: rtl/simt_branch_sequencer.sv
// Turns one resolved branch at a time into the SIMT stack write sequence.
// Per-warp stack depth is tracked so that a branch that would overflow is dropped and flagged.
module simt_branch_sequencer #(
    parameter int NUM_WARP_LOG    = 3,
    parameter int SIZE_PC         = 32,
    parameter int SIZE_CORE       = 8,
    parameter int STACK_DEPTH_LOG = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall_i,
    input  logic                              br_valid_i,
    output logic                              br_ready_o,
    input  logic [NUM_WARP_LOG-1:0]           br_warp_i,
    input  logic [SIZE_CORE-1:0]              active_mask_i,
    input  logic [SIZE_CORE-1:0]              taken_mask_i,
    input  logic [SIZE_PC-1:0]                target_pc_i,
    input  logic [SIZE_PC-1:0]                fallthru_pc_i,
    input  logic [SIZE_PC-1:0]                rpc_i,
    input  logic [SIZE_PC-1:0]                rpc_tos_i,
    input  logic                              reconv_i,
    input  logic [NUM_WARP_LOG-1:0]           reconv_warp_i,
    output logic                              branch_o,
    output logic                              push_state_o,
    output logic [NUM_WARP_LOG-1:0]           branch_warp_o,
    output logic [NUM_WARP_LOG-1:0]           pre_branch_warp_o,
    output logic                              push_tos_o,
    output logic                              push_tossub1_o,
    output logic [2*SIZE_PC+SIZE_CORE-1:0]    packet_tos_o,
    output logic [2*SIZE_PC+SIZE_CORE-1:0]    packet_tossub1_o,
    output logic                              busy_o,
    output logic [NUM_WARP_LOG-1:0]           busy_warp_o,
    output logic                              overflow_o
);
    localparam int NUM_WARP = 2 ** NUM_WARP_LOG;
    localparam int SIZE_PKT = 2 * SIZE_PC + SIZE_CORE;
    localparam logic [STACK_DEPTH_LOG:0]   DEPTH_MAX  = (STACK_DEPTH_LOG+1)'((2 ** STACK_DEPTH_LOG) - 1);
    localparam logic [STACK_DEPTH_LOG:0]   DEPTH_STEP = (STACK_DEPTH_LOG+1)'(2);
    localparam logic [STACK_DEPTH_LOG-1:0] DEPTH_ZERO = STACK_DEPTH_LOG'(0);
    localparam logic [STACK_DEPTH_LOG-1:0] DEPTH_ONE  = STACK_DEPTH_LOG'(1);
    localparam logic [STACK_DEPTH_LOG-1:0] DEPTH_TWO  = STACK_DEPTH_LOG'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UNI  = 2'd1,
        S_PH1  = 2'd2,
        S_PH2  = 2'd3
    } state_t;

    state_t                      r_state;
    logic [NUM_WARP_LOG-1:0]     r_warp;
    logic [SIZE_PC-1:0]          r_rpc;
    logic [SIZE_PC-1:0]          r_target;
    logic [SIZE_PC-1:0]          r_fallthru;
    logic [SIZE_CORE-1:0]        r_m1;
    logic [SIZE_CORE-1:0]        r_m0;
    logic                        r_branch;
    logic                        r_push_state;
    logic                        r_push_tos;
    logic                        r_push_tossub1;
    logic [NUM_WARP_LOG-1:0]     r_branch_warp;
    logic [NUM_WARP_LOG-1:0]     r_pre_branch_warp;
    logic [SIZE_PKT-1:0]         r_packet_tos;
    logic [SIZE_PKT-1:0]         r_packet_tossub1;
    logic                        r_busy;
    logic                        r_overflow;
    logic [STACK_DEPTH_LOG-1:0]  r_depth [NUM_WARP];

    logic                        w_accept;
    logic [SIZE_CORE-1:0]        w_m1;
    logic [SIZE_CORE-1:0]        w_m0;
    logic                        w_any1;
    logic                        w_any0;
    logic                        w_divergent;
    logic                        w_uniform;
    logic [STACK_DEPTH_LOG-1:0]  w_depth_br;
    logic [STACK_DEPTH_LOG-1:0]  w_depth_rc;
    logic                        w_fits;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_pop;
    logic                        w_underflow;

    assign br_ready_o  = (r_state == S_IDLE) & ~stall_i;
    assign w_accept    = br_valid_i & br_ready_o;
    assign w_m1        = active_mask_i & taken_mask_i;
    assign w_m0        = active_mask_i & ~taken_mask_i;
    assign w_any1      = |w_m1;
    assign w_any0      = |w_m0;
    assign w_divergent = w_accept & w_any1 & w_any0;
    assign w_uniform   = w_accept & (w_any1 ^ w_any0);
    assign w_depth_br  = r_depth[br_warp_i];
    assign w_depth_rc  = r_depth[reconv_warp_i];
    assign w_fits      = ({1'b0, w_depth_br} + DEPTH_STEP) <= DEPTH_MAX;
    assign w_push      = w_divergent & w_fits;
    assign w_drop      = w_divergent & ~w_fits;
    assign w_pop       = reconv_i & ~stall_i;
    // A pop on an empty stack is only an error if no push lands on that warp in the same cycle
    assign w_underflow = w_pop & (w_depth_rc == DEPTH_ZERO) & ~(w_push & (br_warp_i == reconv_warp_i));

    // Per-warp depth tracking and the sticky overflow/underflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WARP; i++) begin
                r_depth[i] <= DEPTH_ZERO;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARP; i++) begin
                if (w_push && (br_warp_i == NUM_WARP_LOG'(i)) && w_pop && (reconv_warp_i == NUM_WARP_LOG'(i))) begin
                    r_depth[i] <= r_depth[i] + DEPTH_ONE;
                end else if (w_push && (br_warp_i == NUM_WARP_LOG'(i))) begin
                    r_depth[i] <= r_depth[i] + DEPTH_TWO;
                end else if (w_pop && (reconv_warp_i == NUM_WARP_LOG'(i)) && (r_depth[i] != DEPTH_ZERO)) begin
                    r_depth[i] <= r_depth[i] - DEPTH_ONE;
                end else begin
                    r_depth[i] <= r_depth[i];
                end
            end
            r_overflow <= r_overflow | w_drop | w_underflow;
        end
    end

    // Sequencing FSM with registered strobes, packets and request latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_warp            <= {NUM_WARP_LOG{1'b0}};
            r_rpc             <= {SIZE_PC{1'b0}};
            r_target          <= {SIZE_PC{1'b0}};
            r_fallthru        <= {SIZE_PC{1'b0}};
            r_m1              <= {SIZE_CORE{1'b0}};
            r_m0              <= {SIZE_CORE{1'b0}};
            r_branch          <= 1'b0;
            r_push_state      <= 1'b0;
            r_push_tos        <= 1'b0;
            r_push_tossub1    <= 1'b0;
            r_branch_warp     <= {NUM_WARP_LOG{1'b0}};
            r_pre_branch_warp <= {NUM_WARP_LOG{1'b0}};
            r_packet_tos      <= {SIZE_PKT{1'b0}};
            r_packet_tossub1  <= {SIZE_PKT{1'b0}};
            r_busy            <= 1'b0;
        end else if (stall_i) begin
            r_branch       <= 1'b0;
            r_push_state   <= 1'b0;
            r_push_tos     <= 1'b0;
            r_push_tossub1 <= 1'b0;
        end else begin
            r_branch       <= 1'b0;
            r_push_state   <= 1'b0;
            r_push_tos     <= 1'b0;
            r_push_tossub1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_warp     <= br_warp_i;
                        r_rpc      <= rpc_i;
                        r_target   <= target_pc_i;
                        r_fallthru <= fallthru_pc_i;
                        r_m1       <= w_m1;
                        r_m0       <= w_m0;
                    end
                    if (w_push) begin
                        r_state       <= S_PH1;
                        r_busy        <= 1'b1;
                        r_branch      <= 1'b1;
                        r_push_tos    <= 1'b1;
                        r_branch_warp <= br_warp_i;
                        r_packet_tos  <= {rpc_tos_i, rpc_i, active_mask_i};
                    end else if (w_uniform) begin
                        r_state           <= S_UNI;
                        r_busy            <= 1'b1;
                        r_push_state      <= 1'b1;
                        r_push_tos        <= 1'b1;
                        r_pre_branch_warp <= br_warp_i;
                        r_packet_tos      <= {rpc_tos_i, (w_any1 ? target_pc_i : fallthru_pc_i), active_mask_i};
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_PH1: begin
                    r_state           <= S_PH2;
                    r_busy            <= 1'b1;
                    r_push_state      <= 1'b1;
                    r_push_tos        <= 1'b1;
                    r_push_tossub1    <= 1'b1;
                    r_pre_branch_warp <= r_warp;
                    r_packet_tos      <= {r_rpc, r_target, r_m1};
                    r_packet_tossub1  <= {r_rpc, r_fallthru, r_m0};
                end
                S_UNI, S_PH2: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign branch_o          = r_branch;
    assign push_state_o      = r_push_state;
    assign push_tos_o        = r_push_tos;
    assign push_tossub1_o    = r_push_tossub1;
    assign branch_warp_o     = r_branch_warp;
    assign pre_branch_warp_o = r_pre_branch_warp;
    assign packet_tos_o      = r_packet_tos;
    assign packet_tossub1_o  = r_packet_tossub1;
    assign busy_o            = r_busy;
    assign busy_warp_o       = r_warp;
    assign overflow_o        = r_overflow;

endmodule

// File: tb/tb_simt_branch_sequencer.sv
// Scoreboard bench for simt_branch_sequencer: directed test-plan scenarios followed by
// randomized traffic checked against a queue-based behavioural model.
module tb_simt_branch_sequencer;
    localparam int NWL  = 3;
    localparam int PCW  = 32;
    localparam int CORE = 8;
    localparam int SDL  = 6;
    localparam int NW   = 8;
    localparam int PKT  = 2 * PCW + CORE;
    localparam int DMAX = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall_i, br_valid_i, br_ready_o, reconv_i;
    logic [NWL-1:0] br_warp_i, reconv_warp_i, branch_warp_o, pre_branch_warp_o, busy_warp_o;
    logic [CORE-1:0] active_mask_i, taken_mask_i;
    logic [PCW-1:0] target_pc_i, fallthru_pc_i, rpc_i, rpc_tos_i;
    logic branch_o, push_state_o, push_tos_o, push_tossub1_o, busy_o, overflow_o;
    logic [PKT-1:0] packet_tos_o, packet_tossub1_o;
    logic [3:0] w_strb;

    assign w_strb = {branch_o, push_state_o, push_tos_o, push_tossub1_o};

    simt_branch_sequencer #(.NUM_WARP_LOG(NWL), .SIZE_PC(PCW), .SIZE_CORE(CORE), .STACK_DEPTH_LOG(SDL)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
        .br_warp_i(br_warp_i), .active_mask_i(active_mask_i), .taken_mask_i(taken_mask_i),
        .target_pc_i(target_pc_i), .fallthru_pc_i(fallthru_pc_i), .rpc_i(rpc_i), .rpc_tos_i(rpc_tos_i),
        .reconv_i(reconv_i), .reconv_warp_i(reconv_warp_i), .branch_o(branch_o), .push_state_o(push_state_o),
        .branch_warp_o(branch_warp_o), .pre_branch_warp_o(pre_branch_warp_o), .push_tos_o(push_tos_o),
        .push_tossub1_o(push_tossub1_o), .packet_tos_o(packet_tos_o), .packet_tossub1_o(packet_tossub1_o),
        .busy_o(busy_o), .busy_warp_o(busy_warp_o), .overflow_o(overflow_o)
    );

    typedef struct packed {
        logic [3:0]     strb;   // {branch, push_state, push_tos, push_tossub1}
        logic [NWL-1:0] warp;
        logic [PKT-1:0] ptos;
        logic [PKT-1:0] psub;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_acc = 0;
    int  m_depth [NW];
    bit  m_ovf;
    logic stall_q = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input logic [3:0] s, input logic [NWL-1:0] w,
                                  input logic [PKT-1:0] pt, input logic [PKT-1:0] ps);
        ev_t e;
        e.strb = s; e.warp = w; e.ptos = pt; e.psub = ps;
        return e;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < NW; i++) m_depth[i] = 0;
        m_ovf = 1'b0;
    endtask

    always @(posedge clk) stall_q <= stall_i;

    // Monitor: every strobe cycle must match the oldest expected stack write
    always @(negedge clk) begin : monitor
        ev_t e;
        if (reset === 1'b1) begin
            if (stall_q === 1'b1) chk("stall_quiet", w_strb, 4'b0000);
            if (w_strb !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", w_strb, 4'b0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobes", w_strb, e.strb);
                    chk("warp", e.strb[3] ? branch_warp_o : pre_branch_warp_o, e.warp);
                    chk("packet_tos", packet_tos_o, e.ptos);
                    if (e.strb[0]) chk("packet_tossub1", packet_tossub1_o, e.psub);
                end
            end
        end
    end

    // One clock of stimulus; the model reacts to whatever the DUT accepted
    task automatic cycle(input bit v, input bit [NWL-1:0] w, input bit [CORE-1:0] act, input bit [CORE-1:0] tak,
                         input bit [PCW-1:0] tgt, input bit [PCW-1:0] fall, input bit [PCW-1:0] rpc,
                         input bit [PCW-1:0] rtos, input bit st, input bit rc, input bit [NWL-1:0] rw,
                         output bit acc);
        bit [CORE-1:0] m1, m0;
        int inc_w;
        br_valid_i = v; br_warp_i = w; active_mask_i = act; taken_mask_i = tak;
        target_pc_i = tgt; fallthru_pc_i = fall; rpc_i = rpc; rpc_tos_i = rtos;
        stall_i = st; reconv_i = rc; reconv_warp_i = rw;
        #1;
        acc = v && (br_ready_o === 1'b1);
        m1 = act & tak;
        m0 = act & ~tak;
        inc_w = -1;
        if (acc) begin
            if (m1 != 0 && m0 != 0) begin
                if (m_depth[w] + 2 <= DMAX) begin
                    exp_q.push_back(mk_ev(4'b1010, w, {rtos, rpc, act}, '0));
                    exp_q.push_back(mk_ev(4'b0111, w, {rpc, tgt, m1}, {rpc, fall, m0}));
                    inc_w = int'(w);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m1 != 0 || m0 != 0) begin
                exp_q.push_back(mk_ev(4'b0110, w, {rtos, ((m1 != 0) ? tgt : fall), act}, '0));
            end
        end
        if (inc_w >= 0) m_depth[inc_w] += 2;
        if (rc && !st) begin
            if (m_depth[rw] > 0) m_depth[rw] -= 1;
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        br_valid_i = 1'b0;
        reconv_i = 1'b0;
    endtask

    task automatic req(input bit [NWL-1:0] w, input bit [CORE-1:0] act, input bit [CORE-1:0] tak,
                       input bit rc, input bit [NWL-1:0] rw);
        bit acc;
        cycle(1'b1, w, act, tak, 32'h100, 32'h080, 32'h200, 32'h300, 1'b0, rc, rw, acc);
        chk("accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n, input bit st);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, st, 1'b0, '0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit acc, v, st, rc;
        bit [NWL-1:0] w, rw;
        bit [CORE-1:0] act, tak;
        int r;

        reset = 1'b0; stall_i = 1'b0; br_valid_i = 1'b0; reconv_i = 1'b0;
        br_warp_i = '0; reconv_warp_i = '0; active_mask_i = '0; taken_mask_i = '0;
        target_pc_i = '0; fallthru_pc_i = '0; rpc_i = '0; rpc_tos_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {w_strb, busy_o, overflow_o, branch_warp_o, pre_branch_warp_o, busy_warp_o}, '0);
        chk("reset_pkt_tos", packet_tos_o, '0);
        chk("reset_pkt_sub1", packet_tossub1_o, '0);
        chk("reset_ready", br_ready_o, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Divergent branch on warp 2
        req(3'd2, 8'hFF, 8'h0F, 1'b0, 3'd0);
        chk("div_ph1_strobes", w_strb, 4'b1010);
        chk("div_ph1_packet", packet_tos_o, {32'h300, 32'h200, 8'hFF});
        chk("div_busy", {busy_o, busy_warp_o, branch_warp_o}, {1'b1, 3'd2, 3'd2});
        chk("div_ready_low", br_ready_o, 1'b0);
        idle(1, 1'b0);
        chk("div_ph2_strobes", w_strb, 4'b0111);
        chk("div_ph2_tos", packet_tos_o, {32'h200, 32'h100, 8'h0F});
        chk("div_ph2_tossub1", packet_tossub1_o, {32'h200, 32'h080, 8'hF0});
        chk("div_depth", dut.r_depth[2], 6'd2);
        idle(1, 1'b0);
        chk("div_done", {w_strb, busy_o, br_ready_o}, 6'b000001);

        // Uniform (not taken) on warp 1
        req(3'd1, 8'h3C, 8'h00, 1'b0, 3'd0);
        chk("uni_strobes", w_strb, 4'b0110);
        chk("uni_packet", packet_tos_o, {32'h300, 32'h080, 8'h3C});
        chk("uni_ready_low", br_ready_o, 1'b0);
        idle(1, 1'b0);
        chk("uni_done", {w_strb, busy_o, br_ready_o}, 6'b000001);
        chk("uni_depth", dut.r_depth[1], 6'd0);

        // Null branch on warp 4
        req(3'd4, 8'h00, 8'h5A, 1'b0, 3'd0);
        chk("null_quiet", {w_strb, busy_o, br_ready_o}, 6'b000001);
        chk("null_depth", dut.r_depth[4], 6'd0);

        // Stall for three cycles while in PH1
        req(3'd3, 8'hF0, 8'h30, 1'b0, 3'd0);
        chk("stall_ph1", w_strb, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b1);
            chk("stall_strobes", w_strb, 4'b0000);
            chk("stall_ready", br_ready_o, 1'b0);
        end
        chk("stall_depth_held", dut.r_depth[3], 6'd2);
        idle(1, 1'b0);
        chk("stall_ph2_after_release", w_strb, 4'b0111);
        idle(1, 1'b0);
        chk("stall_depth", dut.r_depth[3], 6'd2);

        // Fill warp 0 to depth 62, then the next divergent branch is dropped
        for (int i = 0; i < 31; i++) begin
            req(3'd0, 8'hFF, 8'h0F, 1'b0, 3'd0);
            idle(2, 1'b0);
        end
        chk("fill_depth", dut.r_depth[0], 6'd62);
        chk("fill_no_ovf", overflow_o, 1'b0);
        req(3'd0, 8'hFF, 8'h0F, 1'b0, 3'd0);
        chk("ovf_drop_quiet", {w_strb, busy_o, br_ready_o}, 6'b000001);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_depth", dut.r_depth[0], 6'd62);
        cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 3'd0, acc);
        chk("reconv_depth", dut.r_depth[0], 6'd61);
        req(3'd0, 8'hFF, 8'h0F, 1'b1, 3'd0);
        chk("push_pop_ph1", w_strb, 4'b1010);
        idle(2, 1'b0);
        chk("push_pop_depth", dut.r_depth[0], 6'd62);

        // Asynchronous reset during PH1
        req(3'd6, 8'hFF, 8'h0F, 1'b0, 3'd0);
        chk("rst_ph1", w_strb, 4'b1010);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_ctrl", {w_strb, busy_o, overflow_o, branch_warp_o, pre_branch_warp_o, busy_warp_o}, '0);
        chk("rst_pkt", packet_tos_o, '0);
        chk("rst_ready", br_ready_o, 1'b1);
        chk("rst_depth", dut.r_depth[0], 6'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        idle(3, 1'b0);
        chk("rst_no_ph2", {w_strb, busy_o}, 5'b00000);

        // Reconvergence on an empty stack
        cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 3'd5, acc);
        chk("underflow_flag", overflow_o, 1'b1);
        chk("underflow_depth", dut.r_depth[5], 6'd0);

        reset = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int k = 0; k < 1200; k++) begin
            v  = ($urandom_range(9) < 7);
            w  = NWL'($urandom_range(NW - 1));
            r  = $urandom_range(7);
            act = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            r  = $urandom_range(7);
            tak = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            st = ($urandom_range(9) == 0);
            rw = NWL'($urandom_range(NW - 1));
            rc = ($urandom_range(4) == 0) && (m_depth[rw] > 0);
            cycle(v, w, act, tak, $urandom, $urandom, $urandom, $urandom, st, rc, rw, acc);
            if (acc) n_acc++;
            chk("rand_overflow", overflow_o, m_ovf);
        end
        idle(4, 1'b0);
        chk("drain_queue", exp_q.size(), 0);
        chk("accept_count", (n_acc > 50), 1'b1);
        for (int i = 0; i < NW; i++) chk("final_depth", dut.r_depth[i], m_depth[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
